buttons_debouncer: RTL and testbench
====================================

# buttons_debouncer

Conditions raw push-button inputs before they reach the buttons bus interface. Each channel is synchronised into `clk` through a two-flop chain and filtered by a per-channel stability counter. The block emits a clean, glitch-free, active-high level per button. Its outputs drive the bus interface's `btn_0..btn_3` inputs directly, so that block's rising-edge detectors see exactly one edge per physical press.

## Interface
- `CHANNELS`, 4: number of independent button channels.
- `STABLE_CYCLES`, 500000: consecutive `clk` cycles a new level must persist before it is accepted (10 ms at 50 MHz). Legal values are ≥ 2.
- `ACTIVE_LOW`, 1: when 1, a raw input of 0 means pressed and inputs are inverted after synchronisation. When 0, inputs are taken as-is.
- `clk` input 1: single clock; all state is updated on its rising edge.
- `rst` input 1: reset, synchronous and active-low; sampled on `clk` rising edge.
- `raw_btn` input `CHANNELS`: asynchronous physical button pins.
- `btn` output `CHANNELS`: debounced level, 1 = pressed. Bit i feeds the bus interface's `btn_i`.
- `btn_busy` output `CHANNELS`: 1 while channel i is in a pending state (diagnostic).

## Operation
- Per channel: `raw_btn[i]` → `s1` → `s2`, then optional inversion (`ACTIVE_LOW`) to give `lvl`. All further logic uses `lvl` only.
- Per-channel FSM states: `ST_RELEASED`, `ST_PEND_PRESS`, `ST_PRESSED`, `ST_PEND_RELEASE`.
- `ST_RELEASED`, `lvl`=1 → `ST_PEND_PRESS`, `cnt`←1. With `lvl`=0 it stays.
- `ST_PEND_PRESS`, `lvl`=0 → `ST_RELEASED`, `cnt`←0 (bounce aborts).
- `ST_PEND_PRESS`, `lvl`=1 and `cnt`==`STABLE_CYCLES`−1 → `ST_PRESSED`, `btn[i]`←1, `cnt`←0.
- `ST_PEND_PRESS`, `lvl`=1 otherwise → `cnt`←`cnt`+1.
- `ST_PRESSED` and `ST_PEND_RELEASE` mirror the press path with polarity swapped; `btn[i]`←0 on acceptance.
- `btn[i]` is 1 exactly in `ST_PRESSED` and `ST_PEND_RELEASE`. `btn_busy[i]` is 1 exactly in the two pending states.
- Counter width is `$clog2(STABLE_CYCLES)`. It never exceeds `STABLE_CYCLES`−1, so it never wraps.
- Channels are fully independent. Simultaneous activity on several channels has no interaction.

## Timing
- Reset (`rst`=0 at a clock edge): `s1`, `s2` load the released raw value (1 if `ACTIVE_LOW`, else 0), all FSMs go to `ST_RELEASED`, `cnt`=0, `btn`=0, `btn_busy`=0.
- Reset mid-pending discards progress; no output change is produced.
- A button held through reset is reported pressed `STABLE_CYCLES`+2 cycles after release of `rst`.
- Latency: a raw change captured into `s1` at edge k reaches `lvl` at edge k+1, and `btn` changes at edge k+1+`STABLE_CYCLES`, provided `lvl` is unchanged for those `STABLE_CYCLES` cycles.
- A bounce lasting any number of cycles up to `STABLE_CYCLES`−1 produces no output change.
- `btn` is a registered output: no combinational path from `raw_btn`, and it changes at most once per `STABLE_CYCLES` cycles per channel.

## Configuration
- `BUTTONS_DEBOUNCE_EN` defined: full FSM and counter as above.
- `BUTTONS_DEBOUNCE_EN` undefined: FSM and counters are not compiled. `btn[i]` is a register loading `lvl` every cycle, giving 3-cycle latency from raw edge (edge k into `s1`, `btn` at edge k+2). `btn_busy` is tied to 0.
- The undefined build is intended for fast simulation and is functionally identical apart from bounce filtering.

## Structure
- Package `buttons_pkg`: enum typedef `debounce_state_t` (the four states) and constant `BTN_RELEASED_RAW` derivation helper.
- Sub-module `debounce_channel`: one synchroniser, FSM and counter, parameterised by `STABLE_CYCLES` and `ACTIVE_LOW`.
- The top instantiates `CHANNELS` copies in a generate loop.

## Test plan
Use `STABLE_CYCLES`=4 and `ACTIVE_LOW`=1 unless noted.
- **Reset values.** Hold `rst`=0 for 2 cycles with `raw_btn`=4'b1111, then release → `btn`=0 and `btn_busy`=0 through all following cycles.
- **Clean press and release.** Drive `raw_btn[0]` 1→0 at edge k and hold → `btn[0]`=1 at edge k+5. Return to 1 at edge m → `btn[0]`=0 at edge m+5. Other bits stay 0 throughout.
- **Bounce rejection.** Pulse `raw_btn[1]` low for 3 cycles, high for 1, low for 2, then high → `btn[1]` never asserts, and `btn_busy[1]` pulses during each low run.
- **Reset mid-pending.** `raw_btn[2]` goes low, then `rst`=0 after 2 cycles for one cycle → `btn[2]`=0, `btn_busy[2]`=0, and with input still low `btn[2]`=1 six cycles after `rst` returns to 1.
- **Simultaneous channels.** Press all 4 buttons at the same edge with channel 3 bouncing once → channels 0–2 assert together and channel 3 asserts later by its bounce length plus 1.
- **Macro off.** Rebuild without `BUTTONS_DEBOUNCE_EN` → a 1-cycle low glitch on `raw_btn[0]` appears as a 1-cycle `btn[0]` pulse 3 edges later, and `btn_busy`=0 throughout.

Source files
------------

// File: rtl/buttons_pkg.sv
// buttons_pkg: shared debouncer state type and released-level helper
package buttons_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PEND_PRESS,
        ST_PRESSED,
        ST_PEND_RELEASE
    } debounce_state_t;

    // Raw pin level of an idle button: high for active-low wiring, low otherwise
    function automatic logic btn_released_raw(input bit active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button synchroniser plus stability filter (filter built only with BUTTONS_DEBOUNCE_EN)
module debounce_channel
    import buttons_pkg::*;
#(
    parameter int STABLE_CYCLES = 500000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic btn,
    output logic busy
);

    localparam logic REL = btn_released_raw(ACTIVE_LOW);

    logic s1, s2, lvl;

    // Two-flop synchroniser, preset to the idle pin level so reset never looks like a press
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= REL;
            s2 <= REL;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    assign lvl = ACTIVE_LOW ? ~s2 : s2;

`ifdef BUTTONS_DEBOUNCE_EN

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    debounce_state_t state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;

    // State and stability counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A new level is accepted only after it has been seen STABLE_CYCLES times in a row
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_RELEASED: begin
                if (lvl) begin
                    state_nx = ST_PEND_PRESS;
                    cnt_nx   = CW'(1);
                end
            end
            ST_PEND_PRESS: begin
                if (!lvl) begin
                    state_nx = ST_RELEASED;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = ST_PRESSED;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_PRESSED: begin
                if (!lvl) begin
                    state_nx = ST_PEND_RELEASE;
                    cnt_nx   = CW'(1);
                end
            end
            ST_PEND_RELEASE: begin
                if (lvl) begin
                    state_nx = ST_PRESSED;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = ST_RELEASED;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = ST_RELEASED;
                cnt_nx   = '0;
            end
        endcase
    end

    assign btn  = (state == ST_PRESSED) || (state == ST_PEND_RELEASE);
    assign busy = (state == ST_PEND_PRESS) || (state == ST_PEND_RELEASE);

`else

    // Unfiltered build: output simply registers the synchronised level
    always_ff @(posedge clk) begin
        if (!rst) btn <= 1'b0;
        else      btn <= lvl;
    end

    assign busy = 1'b0;

`endif

endmodule

// File: rtl/buttons_debouncer.sv
// buttons_debouncer: CHANNELS independent debounced buttons (filtering enabled by BUTTONS_DEBOUNCE_EN)
module buttons_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 500000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw_btn,
    output logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] btn_busy
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .raw (raw_btn[i]),
            .btn (btn[i]),
            .busy(btn_busy[i])
        );
    end

endmodule

// File: tb/tb_buttons_debouncer.sv
// tb_buttons_debouncer: randomized + directed scoreboard bench against a run-length reference model
module tb_buttons_debouncer;
  localparam int CH = 4;
  localparam int S = 4;
  localparam bit AL = 1'b1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [CH-1:0] raw_btn = '1;
  logic [CH-1:0] btn, btn_busy;
  int vectors = 0;
  int miscompares = 0;
  int w;
  logic [2*CH-1:0] exp_q[$];
  buttons_debouncer #(.CHANNELS(CH), .STABLE_CYCLES(S), .ACTIVE_LOW(AL)) dut (
    .clk(clk),
    .rst(rst),
    .raw_btn(raw_btn),
    .btn(btn),
    .btn_busy(btn_busy)
  );
  always #5 clk = ~clk;
  bit sync1[CH], sync2[CH], out_m[CH];
  int run[CH];
  initial begin
    forever begin
      logic [CH-1:0] eb, ey;
      bit lvl;
      @(posedge clk);
      for (int c = 0; c < CH; c++) begin
        if (!rst) begin
          sync1[c] = AL;
          sync2[c] = AL;
          out_m[c] = 1'b0;
          run[c] = 0;
        end else begin
          lvl = sync2[c] ^ AL;
`ifdef BUTTONS_DEBOUNCE_EN
          if (lvl != out_m[c]) begin
            run[c] = run[c] + 1;
            if (run[c] == S) begin
              out_m[c] = lvl;
              run[c] = 0;
            end
          end else begin
            run[c] = 0;
          end
`else
          out_m[c] = lvl;
`endif
          sync2[c] = sync1[c];
          sync1[c] = raw_btn[c];
        end
        eb[c] = out_m[c];
        ey[c] = run[c] != 0;
      end
      exp_q.push_back({eb, ey});
    end
  end
  initial begin
    forever begin
      logic [2*CH-1:0] e;
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({btn, btn_busy} !== e) begin
          miscompares++;
          $display("FAIL outputs at %0t: btn=%b busy=%b, expected btn=%b busy=%b",
                   $time, btn, btn_busy, e[2*CH-1:CH], e[CH-1:0]);
        end
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    rst = 1'b0;
    raw_btn = 4'b1111;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    if ({btn, btn_busy} !== '0) begin
      miscompares++;
      $display("FAIL reset state at %0t: btn=%b busy=%b", $time, btn, btn_busy);
    end
    cyc(9);
    raw_btn[0] = 1'b0;
    w = 0;
    while (btn[0] !== 1'b1 && w < 10) begin
      cyc(1);
      w++;
    end
    if (btn[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout waiting for btn[0] press at %0t", $time);
    end
    cyc(10 - w);
    raw_btn[0] = 1'b1; cyc(10);
    raw_btn[1] = 1'b0; cyc(3);
    raw_btn[1] = 1'b1; cyc(1);
    raw_btn[1] = 1'b0; cyc(2);
    raw_btn[1] = 1'b1; cyc(10);
    raw_btn[2] = 1'b0; cyc(2);
    rst = 1'b0; cyc(1);
    rst = 1'b1; cyc(10);
    raw_btn[2] = 1'b1; cyc(10);
    raw_btn = 4'b0000; cyc(1);
    raw_btn[3] = 1'b1; cyc(1);
    raw_btn[3] = 1'b0; cyc(10);
    raw_btn = 4'b1111; cyc(10);
    raw_btn[0] = 1'b0; cyc(1);
    raw_btn[0] = 1'b1; cyc(8);
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 7) == 0) raw_btn[c] = ~raw_btn[c];
      rst = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      cyc(1);
    end
    rst = 1'b1;
    raw_btn = 4'b1111;
    cyc(12);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $display(miscompares == 0 ? "PASS" : "FAIL");
    $finish;
  end
endmodule
